dual_counter_driver: RTL
========================

Name: dual_counter_driver

Overview:
- Stimulus/checking initiator for the dual enable-counter block (two 12-bit counters with `ena1`/`ena2`, plus `valid` = NOT(both counters at all-ones)).
- Drives that block's reset and enables to steer it to a programmed target state, keeps shadow copies of both counters, and cross-checks the visible `count` output cycle by cycle.
- Reports whether `valid` fell at the target; used in simulation benches and as the environment driver in bounded formal runs.

Parameters:
- WIDTH, 12, counter width of the driven block.
- TARGET1, {WIDTH{1'b1}}, value the first counter is stepped to.
- TARGET2, {WIDTH{1'b1}}, value the second counter is stepped to.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse, begins a run; ignored while busy.
- mode  input  2  0 = concurrent ramp, 1 = sequential (counter 1 then counter 2), 2 = counter 1 only, 3 = reserved (treated as 0).
- count_in  input  WIDTH  `count` output of the driven block.
- valid_in  input  1  `valid` output of the driven block.
- dut_rst  output  1  active-high reset to the driven block.
- ena1  output  1  enable for counter 1.
- ena2  output  1  enable for counter 2.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- hit  output  1  `valid_in` sampled 0 in CHECK; held until next start.
- mismatch  output  1  sticky; `count_in` != shadow1 in any RAMP/CHECK cycle.
- cycles  output  WIDTH+2  number of RAMP cycles in the last run.

Behaviour:
- All outputs registered; all state updates on rising `clk`.
- Reset (`rst`=0) values: `dut_rst`=1, `ena1`=`ena2`=0, `busy`=0, `done`=0, `hit`=0, `mismatch`=0, `cycles`=0, shadows=0, state IDLE.
- Reset mid-run: aborts the run, returns to IDLE, no `done` pulse.
- `dut_rst` falls to 0 on the first cycle out of reset and stays 0 in IDLE.
- IDLE:
  - `start`=1 -> CLEAR.
  - On that edge: `busy`=1; `hit`, `mismatch`, `cycles` cleared.
- CLEAR (exactly 1 cycle):
  - `dut_rst`=1; shadow1 and shadow2 zeroed.
  - Next state RAMP, with `dut_rst`=0.
- RAMP:
  - Each cycle `cycles` increments by 1, saturating at all-ones.
  - Mode 0: `ena1`=1 while shadow1 != TARGET1; `ena2`=1 while shadow2 != TARGET2, evaluated independently.
  - Mode 1: `ena1` asserted until shadow1 == TARGET1, then `ena2` until shadow2 == TARGET2. The two are never high together.
  - Mode 2: only `ena1`; `ena2` held 0.
  - Shadow update: shadow1 increments on every edge where `ena1`=1 (same edge the driven block counts); shadow2 likewise with `ena2`.
  - Enables are computed from next-shadow values so that no enable pulse overshoots its target. Shadow values equal TARGET exactly when the enable drops.
  - Exit to CHECK when no enable would be asserted next cycle.
  - A target of 0 gives zero enable cycles for that counter.
- CHECK (1 cycle):
  - Enables are 0.
  - `hit` <= !`valid_in`.
  - `done` pulses.
  - Next state IDLE, `busy`=0.
- Mismatch:
  - In RAMP and CHECK, `count_in` is compared against shadow1 every cycle.
  - Any inequality sets `mismatch`; it stays set until the next `start`.
  - No comparison in IDLE or CLEAR.
- Wrap-around: shadows never wrap, since enables stop at target. `cycles` saturates.
- `start` during CLEAR, RAMP or CHECK: ignored, with no effect.
- `start` in the same cycle as `rst`=0: reset wins.
- Expected RAMP lengths (defaults):
  - Mode 0: 4095 cycles.
  - Mode 1: 8190 cycles.
  - Mode 2: 4095 cycles.

Decomposition:
- Shared package `counter_drv_pkg` holds:
  - state enum: IDLE, CLEAR, RAMP, CHECK;
  - mode constants: MODE_CONC=0, MODE_SEQ=1, MODE_ONE=2;
  - default WIDTH.
- One natural sub-module, `shadow_counter`: WIDTH-bit clear/enable counter with a target-reached flag, instantiated twice.

Test Plan:
- Mode 0, defaults, driven block connected, `start` pulse -> `busy` for 4097 cycles; `cycles`=4095; `done` pulse; `hit`=1; `mismatch`=0.
- Mode 1 -> `ena1` high 4095 cycles, then `ena2` high 4095 cycles, never overlapping; `cycles`=8190; `hit`=1.
- Mode 2 -> `ena2` never high; final `count_in`=12'hfff; `hit`=0 (`valid` stays 1).
- Mode 0 with `count_in` forced +1 from cycle 100 of RAMP -> `mismatch`=1 at `done`; cleared by next `start`.
- `rst`=0 asserted at RAMP cycle 2000 -> next cycle: `dut_rst`=1, `ena1`=`ena2`=0, `busy`=0, no `done` pulse; a fresh `start` then runs the full sequence correctly.
- TARGET1=0, TARGET2=3, mode 0 -> `ena1` never high, `ena2` high 3 cycles, `cycles`=3, `hit`=0.

Source files
------------

// File: rtl/counter_drv_pkg.sv
// Shared types and constants for the dual enable-counter driver.
// Mode 3 is reserved and folds onto concurrent ramping.
package counter_drv_pkg;

  localparam int unsigned DefaultWidth = 12;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRamp,
    StCheck
  } state_e;

  localparam logic [1:0] MODE_CONC = 2'd0;
  localparam logic [1:0] MODE_SEQ  = 2'd1;
  localparam logic [1:0] MODE_ONE  = 2'd2;

  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_CONC : mode;
  endfunction

endpackage

// File: rtl/shadow_counter.sv
// Clear/enable counter mirroring one counter of the driven block.
// reached_o looks at the next-state value so callers can stop an enable exactly on target.
module shadow_counter
  import counter_drv_pkg::*;
#(
  parameter int unsigned      Width  = DefaultWidth,
  parameter logic [Width-1:0] Target = {Width{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             reached_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign reached_o = (count_d == Target);

endmodule

// File: rtl/dual_counter_driver.sv
// Steers the dual enable-counter block to a programmed target, shadows both counters and
// cross-checks its count output each cycle of a run.
module dual_counter_driver
  import counter_drv_pkg::*;
#(
  parameter int unsigned      WIDTH   = DefaultWidth,
  parameter logic [WIDTH-1:0] TARGET1 = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TARGET2 = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid_in,
  output logic             dut_rst,
  output logic             ena1,
  output logic             ena2,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             mismatch,
  output logic [WIDTH+1:0] cycles
);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] shadow1, shadow2;
  logic             reached1, reached2;
  logic             ena1_nxt, ena2_nxt;
  logic             shadow_clr;
  logic             unused_shadow2;

  assign shadow_clr     = (state_q == StClear);
  assign unused_shadow2 = ^shadow2;

  shadow_counter #(
    .Width  (WIDTH),
    .Target (TARGET1)
  ) u_shadow1 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (shadow_clr),
    .en_i      (ena1),
    .count_o   (shadow1),
    .reached_o (reached1)
  );

  shadow_counter #(
    .Width  (WIDTH),
    .Target (TARGET2)
  ) u_shadow2 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (shadow_clr),
    .en_i      (ena2),
    .count_o   (shadow2),
    .reached_o (reached2)
  );

  // Enables follow the next shadow values, so each one drops on the edge its target is reached.
  always_comb begin
    ena1_nxt = !reached1;
    case (mode_q)
      MODE_SEQ: ena2_nxt = reached1 && !reached2;
      MODE_ONE: ena2_nxt = 1'b0;
      default:  ena2_nxt = !reached2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      mode_q   <= MODE_CONC;
      dut_rst  <= 1'b1;
      ena1     <= 1'b0;
      ena2     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      mismatch <= 1'b0;
      cycles   <= '0;
    end else begin
      dut_rst <= 1'b0;
      ena1    <= 1'b0;
      ena2    <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StClear;
            mode_q   <= norm_mode(mode);
            dut_rst  <= 1'b1;
            busy     <= 1'b1;
            hit      <= 1'b0;
            mismatch <= 1'b0;
            cycles   <= '0;
          end
        end
        StClear: begin
          state_q <= StRamp;
          ena1    <= ena1_nxt;
          ena2    <= ena2_nxt;
        end
        StRamp: begin
          if (count_in != shadow1) mismatch <= 1'b1;
          if (cycles != '1) cycles <= cycles + {{(WIDTH+1){1'b0}}, 1'b1};
          ena1 <= ena1_nxt;
          ena2 <= ena2_nxt;
          if (!ena1_nxt && !ena2_nxt) state_q <= StCheck;
        end
        StCheck: begin
          if (count_in != shadow1) mismatch <= 1'b1;
          hit     <= !valid_in;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
